// File: rtl/color_manager_report_encoder_if.sv
// Report-encoder bus: event/status strobes in, TX FIFO byte stream out.
// The master side produces events and owns the FIFO; the encoder is the slave.
interface color_manager_report_encoder_if #(
    parameter int UART_DATA_WIDTH           = 8,
    parameter int CONFIG_NOTIFICATION_WIDTH = 4,
    parameter int CONFIG_ERROR_WIDTH        = 4,
    parameter int CONFIG_STATUS_WIDTH       = 4
);
    logic [CONFIG_NOTIFICATION_WIDTH-1:0] Config_Notification;
    logic                                 Config_Notification_Valid;
    logic [CONFIG_ERROR_WIDTH-1:0]        Config_Error;
    logic                                 Error_Valid;
    logic [CONFIG_STATUS_WIDTH-1:0]       Config_Status;
    logic                                 Status_Req;
    logic                                 Full;
    logic [UART_DATA_WIDTH-1:0]           TXD_Data;
    logic                                 Wr_En;
    logic                                 Busy;
    logic                                 Dropped;

    modport master (
        output Config_Notification, Config_Notification_Valid, Config_Error, Error_Valid,
               Config_Status, Status_Req, Full,
        input  TXD_Data, Wr_En, Busy, Dropped
    );

    modport slave (
        input  Config_Notification, Config_Notification_Valid, Config_Error, Error_Valid,
               Config_Status, Status_Req, Full,
        output TXD_Data, Wr_En, Busy, Dropped
    );
endinterface

// File: rtl/color_manager_report_encoder.sv
// Frames error/notification/status events as two-byte reports (header, payload)
// into a TX FIFO, with one-deep pending slots and error > notification > status priority.
module color_manager_report_encoder #(
    parameter int UART_DATA_WIDTH           = 8,
    parameter int CONFIG_NOTIFICATION_WIDTH = 4,
    parameter int CONFIG_ERROR_WIDTH        = 4,
    parameter int CONFIG_STATUS_WIDTH       = 4
) (
    input logic                           Clk,
    input logic                           Rst,
    color_manager_report_encoder_if.slave bus
);

    localparam logic [UART_DATA_WIDTH-1:0] HDR_NTF = UART_DATA_WIDTH'(8'hA1);
    localparam logic [UART_DATA_WIDTH-1:0] HDR_ERR = UART_DATA_WIDTH'(8'hA2);
    localparam logic [UART_DATA_WIDTH-1:0] HDR_STS = UART_DATA_WIDTH'(8'hA3);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HDR  = 2'b01,
        ST_PAY  = 2'b10
    } state_t;

    state_t                               state_r;
    state_t                               next_state_s;
    logic                                 err_pend_r;
    logic [CONFIG_ERROR_WIDTH-1:0]        err_code_r;
    logic                                 ntf_pend_r;
    logic [CONFIG_NOTIFICATION_WIDTH-1:0] ntf_code_r;
    logic                                 sts_pend_r;
    logic                                 load_err_s;
    logic                                 load_ntf_s;
    logic                                 load_sts_s;
    logic [UART_DATA_WIDTH-1:0]           tx_hdr_r;
    logic [UART_DATA_WIDTH-1:0]           tx_pay_r;
    logic [UART_DATA_WIDTH-1:0]           err_ext_s;
    logic [UART_DATA_WIDTH-1:0]           ntf_ext_s;
    logic [UART_DATA_WIDTH-1:0]           sts_ext_s;
    logic [UART_DATA_WIDTH-1:0]           txd_s;
    logic                                 wr_en_s;
    logic                                 drop_s;
    logic                                 dropped_r;

    // Zero-extend each code to a payload byte.
    always_comb begin
        err_ext_s = {UART_DATA_WIDTH{1'b0}};
        ntf_ext_s = {UART_DATA_WIDTH{1'b0}};
        sts_ext_s = {UART_DATA_WIDTH{1'b0}};
        err_ext_s[CONFIG_ERROR_WIDTH-1:0]        = err_code_r;
        ntf_ext_s[CONFIG_NOTIFICATION_WIDTH-1:0] = ntf_code_r;
        sts_ext_s[CONFIG_STATUS_WIDTH-1:0]       = bus.Config_Status;
    end

    // Next-state logic and priority slot selection.
    always_comb begin
        next_state_s = state_r;
        load_err_s   = 1'b0;
        load_ntf_s   = 1'b0;
        load_sts_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (err_pend_r) begin
                    load_err_s   = 1'b1;
                    next_state_s = ST_HDR;
                end else if (ntf_pend_r) begin
                    load_ntf_s   = 1'b1;
                    next_state_s = ST_HDR;
                end else if (sts_pend_r) begin
                    load_sts_s   = 1'b1;
                    next_state_s = ST_HDR;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (!bus.Full) begin
                    next_state_s = ST_PAY;
                end else begin
                    next_state_s = ST_HDR;
                end
            end
            ST_PAY: begin
                if (!bus.Full) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_PAY;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FIFO write port: the byte and strobe follow the state and Full directly.
    always_comb begin
        txd_s   = {UART_DATA_WIDTH{1'b0}};
        wr_en_s = 1'b0;
        case (state_r)
            ST_HDR: begin
                txd_s   = tx_hdr_r;
                wr_en_s = !bus.Full;
            end
            ST_PAY: begin
                txd_s   = tx_pay_r;
                wr_en_s = !bus.Full;
            end
            default: begin
                txd_s   = {UART_DATA_WIDTH{1'b0}};
                wr_en_s = 1'b0;
            end
        endcase
    end

    // A strobe on a slot that stays pending this edge loses the older code.
    assign drop_s = (bus.Error_Valid               && err_pend_r && !load_err_s) ||
                    (bus.Config_Notification_Valid && ntf_pend_r && !load_ntf_s) ||
                    (bus.Status_Req                && sts_pend_r && !load_sts_s);

    // State register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Pending slots: a new capture wins over a same-edge load of that slot.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            err_pend_r <= 1'b0;
            err_code_r <= {CONFIG_ERROR_WIDTH{1'b0}};
            ntf_pend_r <= 1'b0;
            ntf_code_r <= {CONFIG_NOTIFICATION_WIDTH{1'b0}};
            sts_pend_r <= 1'b0;
        end else begin
            if (bus.Error_Valid) begin
                err_pend_r <= 1'b1;
                err_code_r <= bus.Config_Error;
            end else if (load_err_s) begin
                err_pend_r <= 1'b0;
            end
            if (bus.Config_Notification_Valid) begin
                ntf_pend_r <= 1'b1;
                ntf_code_r <= bus.Config_Notification;
            end else if (load_ntf_s) begin
                ntf_pend_r <= 1'b0;
            end
            if (bus.Status_Req) begin
                sts_pend_r <= 1'b1;
            end else if (load_sts_s) begin
                sts_pend_r <= 1'b0;
            end
        end
    end

    // TX registers; status payload samples the live status word at load time.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            tx_hdr_r <= {UART_DATA_WIDTH{1'b0}};
            tx_pay_r <= {UART_DATA_WIDTH{1'b0}};
        end else if (load_err_s) begin
            tx_hdr_r <= HDR_ERR;
            tx_pay_r <= err_ext_s;
        end else if (load_ntf_s) begin
            tx_hdr_r <= HDR_NTF;
            tx_pay_r <= ntf_ext_s;
        end else if (load_sts_s) begin
            tx_hdr_r <= HDR_STS;
            tx_pay_r <= sts_ext_s;
        end
    end

    // One-cycle overwrite indication.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            dropped_r <= 1'b0;
        end else begin
            dropped_r <= drop_s;
        end
    end

    assign bus.TXD_Data = txd_s;
    assign bus.Wr_En    = wr_en_s;
    assign bus.Dropped  = dropped_r;
    assign bus.Busy     = (state_r != ST_IDLE) || err_pend_r || ntf_pend_r || sts_pend_r;

endmodule

// File: doc/color_manager_report_encoder.md
COLOR_MANAGER_REPORT_ENCODER -- requirements
Module: color_manager_report_encoder

Interface
REQ-001 SHALL have parameter UART_DATA_WIDTH, default 8, the TX byte width.
REQ-002 SHALL have parameter CONFIG_NOTIFICATION_WIDTH, default 4, the notification code width.
REQ-003 SHALL have parameter CONFIG_ERROR_WIDTH, default 4, the error code width.
REQ-004 SHALL have parameter CONFIG_STATUS_WIDTH, default 4, the status word width.
REQ-005 SHALL have port Clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port Rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port Config_Notification, input, CONFIG_NOTIFICATION_WIDTH, the notification code.
REQ-008 SHALL have port Config_Notification_Valid, input, 1, a one-cycle notification strobe.
REQ-009 SHALL have port Config_Error, input, CONFIG_ERROR_WIDTH, the error code.
REQ-010 SHALL have port Error_Valid, input, 1, a one-cycle error strobe.
REQ-011 SHALL have port Config_Status, input, CONFIG_STATUS_WIDTH, the live status word.
REQ-012 SHALL have port Status_Req, input, 1, a one-cycle status-report request.
REQ-013 SHALL have port Full, input, 1, the TX FIFO full flag.
REQ-014 SHALL have port TXD_Data, output, UART_DATA_WIDTH, the byte written to the TX FIFO.
REQ-015 SHALL have port Wr_En, output, 1, the TX FIFO write strobe.
REQ-016 SHALL have port Busy, output, 1, high when the FSM is not IDLE or any slot is pending.
REQ-017 SHALL have port Dropped, output, 1, a one-cycle pulse when a pending report is overwritten.

Function
REQ-018 SHALL frame each report as two bytes, header then payload: notification header 8'hA1, error 8'hA2, status 8'hA3; payload zero-extended {0..., code}.
REQ-019 SHALL hold three one-deep pending slots (error, notification, status), each with a code register and a pending bit.
REQ-020 SHALL, when a strobe is high at a rising edge, capture its code into its slot and set the pending bit.
REQ-021 SHALL capture Config_Status at slot-load time for status reports, not at Status_Req time.
REQ-022 SHALL, when a strobe hits a slot that is already pending and not being loaded that edge, overwrite the code with the newest value and pulse Dropped for 1 cycle.
REQ-023 SHALL implement FSM states IDLE, HDR and PAY.
REQ-024 SHALL, in IDLE with any slot pending, load the highest-priority slot into the TX registers, clear that pending bit and go to HDR, with priority error > notification > status.
REQ-025 SHALL, in HDR, drive header on TXD_Data and Wr_En = !Full, advancing to PAY only on a cycle where Full=0.
REQ-026 SHALL, in PAY, drive payload with Wr_En = !Full, advancing to IDLE only on a cycle where Full=0.
REQ-027 SHALL hold the state and TXD_Data while Full=1, with Wr_En low and no byte lost or duplicated.
REQ-028 SHALL drive Wr_En and TXD_Data combinationally from the state, the TX registers and Full.
REQ-029 SHALL drive TXD_Data to 0 in IDLE.
REQ-030 SHALL give a latency of header Wr_En in the second cycle after the capture edge (strobe at edge k, load at edge k+1, header write in cycle k+1..k+2) when Full=0 and the FSM is idle.
REQ-031 SHALL insert at least one IDLE cycle between consecutive reports.
REQ-032 SHALL, when a strobe coincides with the same slot being loaded, latch the new capture as pending with no Dropped pulse.
REQ-033 SHALL, when strobes arrive simultaneously, capture all of them independently.

Reset
REQ-034 SHALL, when Rst=0, immediately and asynchronously force IDLE, clear all pending bits and codes, and drive Wr_En=0, TXD_Data=0, Busy=0, Dropped=0.
REQ-035 SHALL discard any report interrupted by reset mid-operation, sending no partial payload after release.
REQ-036 SHALL resume operation on the first rising edge after Rst returns to 1.

Verification
REQ-037 SHALL cover: Error_Valid with Config_Error=4'h3, Full=0 -> writes 8'hA2 then 8'h03 on consecutive cycles; Busy low after.
REQ-038 SHALL cover: Error_Valid=4'h5 and Config_Notification_Valid=4'h1 in the same cycle -> A2,05 then a 1-cycle gap, then A1,01; Dropped stays 0.
REQ-039 SHALL cover: Status_Req with Config_Status=4'h9, Full held 1 for 5 cycles during HDR -> no Wr_En while full; then exactly A3,09.
REQ-040 SHALL cover: three notifications (1, 2, 3) in consecutive cycles while an error is sending -> Dropped pulses twice; only A1,03 is sent after the error.
REQ-041 SHALL cover: Rst=0 asserted during PAY -> Wr_En drops the same cycle; after release there is no payload and the FSM is IDLE.
